// File: rtl/pic_boot_if.sv
// Signal bundle between the boot sequencer and its environment: start request,
// byte-source handshake, program-memory write port and core status.
interface pic_boot_if #(parameter int AW = 10);
    logic          start;
    logic          src_valid;
    logic [7:0]    src_data;
    logic          src_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [13:0]   pm_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    modport master (input  start, src_valid, src_data,
                    output src_ready, pm_we, pm_addr, pm_wdata,
                           core_reset, busy, done, err, err_code);
    modport slave  (output start, src_valid, src_data,
                    input  src_ready, pm_we, pm_addr, pm_wdata,
                           core_reset, busy, done, err, err_code);
endinterface

// File: rtl/pic_boot_sequencer.sv
// Boot controller: holds the core in reset while a length-prefixed byte stream is
// unpacked into 14-bit program words and written to program RAM, then releases it.
module pic_boot_sequencer #(
    parameter int AW        = 10,
    parameter int NUM_WORDS = 1024,
    parameter int HOLD_CYC  = 4,
    parameter int TIMEOUT   = 65535,
    parameter bit AUTOBOOT  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    pic_boot_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI,
        S_WRITE, S_HOLD, S_RUN, S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN   = 16'(NUM_WORDS);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [1:0]  code_nxt;
    logic [7:0]  lo_byte;
    logic [15:0] len;
    logic [15:0] idx;
    logic [15:0] idle_cnt;
    logic [15:0] hold_cnt;
    logic [15:0] len_rx;
    logic        xfer;
    logic        timeout_hit;

    assign xfer        = bus.src_valid & bus.src_ready;
    assign len_rx      = {bus.src_data, lo_byte};
    assign timeout_hit = (TIMEOUT != 0) && bus.src_ready && !bus.src_valid &&
                         (idle_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        code_nxt  = bus.err_code;
        case (state)
            S_IDLE:   if (AUTOBOOT || bus.start) state_nxt = S_LEN_LO;
            S_LEN_LO: if (xfer) state_nxt = S_LEN_HI;
            S_LEN_HI: if (xfer) begin
                if (len_rx == 16'd0 || len_rx > MAX_LEN) begin
                    state_nxt = S_ERROR;
                    code_nxt  = 2'd1;
                end else begin
                    state_nxt = S_DAT_LO;
                end
            end
            S_DAT_LO: if (xfer) state_nxt = S_DAT_HI;
            S_DAT_HI: if (xfer) begin
                // a word with stray top bits is rejected before it reaches memory
                if (bus.src_data[7:6] != 2'b00) begin
                    state_nxt = S_ERROR;
                    code_nxt  = 2'd2;
                end else begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE:  state_nxt = (idx == len - 16'd1) ? S_HOLD : S_DAT_LO;
            S_HOLD:   if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN:    if (bus.start) state_nxt = S_LEN_LO;
            S_ERROR:  if (bus.start) begin
                state_nxt = S_LEN_LO;
                code_nxt  = 2'd0;
            end
            default:  state_nxt = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_nxt = S_ERROR;
            code_nxt  = 2'd3;
        end
    end

    // Outputs are decoded from the next state so each one is a plain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            bus.src_ready  <= 1'b0;
            bus.pm_we      <= 1'b0;
            bus.pm_addr    <= '0;
            bus.pm_wdata   <= '0;
            bus.core_reset <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.err_code   <= 2'd0;
            idle_cnt       <= '0;
            hold_cnt       <= '0;
        end else begin
            state          <= state_nxt;
            bus.src_ready  <= (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                              (state_nxt == S_DAT_LO) || (state_nxt == S_DAT_HI);
            bus.pm_we      <= (state_nxt == S_WRITE);
            if (state_nxt == S_WRITE) begin
                bus.pm_addr  <= idx[AW-1:0];
                bus.pm_wdata <= {bus.src_data[5:0], lo_byte};
            end
            bus.core_reset <= (state_nxt != S_RUN);
            bus.busy       <= (state_nxt != S_IDLE) && (state_nxt != S_RUN) &&
                              (state_nxt != S_ERROR);
            bus.done       <= (state_nxt == S_RUN);
            bus.err        <= (state_nxt == S_ERROR);
            bus.err_code   <= (state_nxt == S_ERROR) ? code_nxt : 2'd0;
            idle_cnt       <= (bus.src_ready && !bus.src_valid) ? idle_cnt + 16'd1 : 16'd0;
            hold_cnt       <= (state == S_HOLD) ? hold_cnt + 16'd1 : 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && (state == S_LEN_LO || state == S_DAT_LO)) lo_byte <= bus.src_data;
        if (xfer && state == S_LEN_HI) begin
            len <= len_rx;
            idx <= '0;
        end
        if (state == S_WRITE) idx <= idx + 16'd1;
    end
endmodule

// File: tb/tb_pic_boot_sequencer.sv
// Bench for pic_boot_sequencer: directed boot scenarios plus randomized images,
// checked against a stream-parsing reference model and a write/timing monitor.
module tb_pic_boot_sequencer;
    localparam int AW        = 10;
    localparam int NUM_WORDS = 1024;
    localparam int HOLD_CYC  = 4;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pic_boot_if #(.AW(AW)) bus ();

    pic_boot_sequencer #(
        .AW(AW), .NUM_WORDS(NUM_WORDS), .HOLD_CYC(HOLD_CYC),
        .TIMEOUT(TIMEOUT), .AUTOBOOT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: records every write and the last core_reset release.
    int            cyc = 0;
    logic [AW-1:0] obs_addr[$];
    logic [13:0]   obs_data[$];
    int            obs_cyc[$];
    int            fall_cyc = -1;
    logic          prev_cr = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pm_we) begin
            obs_addr.push_back(bus.pm_addr);
            obs_data.push_back(bus.pm_wdata);
            obs_cyc.push_back(cyc);
        end
        if (prev_cr && !bus.core_reset) fall_cyc = cyc;
        prev_cr = bus.core_reset;
    end

    // Reference model: parse the byte stream into the writes and final error code.
    logic [7:0]    stream[$];
    logic [AW-1:0] exp_addr[$];
    logic [13:0]   exp_data[$];
    int            exp_code;
    int            exp_used;

    task automatic model();
        int n, p;
        exp_addr.delete();
        exp_data.delete();
        exp_code = 0;
        n = int'({stream[1], stream[0]});
        p = 2;
        if (n == 0 || n > NUM_WORDS) exp_code = 1;
        else begin
            for (int i = 0; i < n; i++) begin
                if (stream[p+1][7:6] != 2'b00) begin
                    exp_code = 2;
                    p += 2;
                    break;
                end
                exp_addr.push_back(AW'(i));
                exp_data.push_back({stream[p+1][5:0], stream[p]});
                p += 2;
            end
        end
        exp_used = p;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int gap_lo, input int gap_hi, input int start_at);
        int g, w;
        for (int k = 0; k < exp_used; k++) begin
            g = $urandom_range(gap_hi, gap_lo);
            bus.src_valid = 1'b0;
            repeat (g) tick();
            bus.src_valid = 1'b1;
            bus.src_data  = stream[k];
            bus.start     = (k == start_at);
            w = 0;
            while (!bus.src_ready && w < 50) begin
                tick();
                bus.start = 1'b0;
                w++;
            end
            if (!bus.src_ready) begin
                chk("byte_accept", 0, 1);
                bus.src_valid = 1'b0;
                bus.start = 1'b0;
                return;
            end
            tick();
            bus.start = 1'b0;
        end
        bus.src_valid = 1'b0;
    endtask

    task automatic wait_end();
        int w = 0;
        while (!(bus.done || bus.err) && w < 300) begin
            tick();
            w++;
        end
        chk("load_end", 32'(bus.done | bus.err), 1);
    endtask

    task automatic run_load(input string tag, input int gap_lo, input int gap_hi, input int start_at);
        int base, ok_gap, last;
        if (bus.done || bus.err) pulse_start();
        base = obs_addr.size();
        model();
        send(gap_lo, gap_hi, start_at);
        wait_end();
        chk($sformatf("%s_nwr", tag), obs_addr.size() - base, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && base + i < obs_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), obs_addr[base+i], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), obs_data[base+i], exp_data[i]);
        end
        chk($sformatf("%s_err", tag), bus.err, (exp_code != 0));
        chk($sformatf("%s_code", tag), bus.err_code, exp_code);
        chk($sformatf("%s_done", tag), bus.done, (exp_code == 0));
        chk($sformatf("%s_core_rst", tag), bus.core_reset, (exp_code != 0));
        if (exp_code == 0 && obs_cyc.size() > base) begin
            last = obs_cyc[obs_cyc.size()-1];
            chk($sformatf("%s_release_dly", tag), fall_cyc - last, HOLD_CYC + 1);
            ok_gap = 1;
            for (int i = base + 1; i < obs_cyc.size(); i++)
                if (obs_cyc[i] - obs_cyc[i-1] < 3) ok_gap = 0;
            chk($sformatf("%s_wr_spacing", tag), ok_gap, 1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_src_ready"}, bus.src_ready, 0);
        chk({tag, "_pm_we"}, bus.pm_we, 0);
        chk({tag, "_pm_addr"}, bus.pm_addr, 0);
        chk({tag, "_pm_wdata"}, bus.pm_wdata, 0);
        chk({tag, "_core_reset"}, bus.core_reset, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_err_code"}, bus.err_code, 0);
    endtask

    task automatic push_word(input logic [13:0] w, input logic [1:0] top);
        stream.push_back(w[7:0]);
        stream.push_back({top, w[13:8]});
    endtask

    task automatic build_random();
        int n, mode, bad;
        n = $urandom_range(5, 1);
        mode = $urandom_range(9, 0);
        stream.delete();
        if (mode == 0) begin
            bad = ($urandom_range(1, 0) == 0) ? 0 : NUM_WORDS + 1 + $urandom_range(100, 0);
            stream.push_back(8'(bad));
            stream.push_back(8'(bad >> 8));
        end else begin
            stream.push_back(8'(n));
            stream.push_back(8'h00);
            for (int i = 0; i < n; i++)
                push_word(14'($urandom), (mode == 1 && i == n - 1) ? 2'($urandom_range(3, 1)) : 2'b00);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        check_reset_vals("por");
        reset = 1'b0;
        tick();
        chk("autoboot_ready", bus.src_ready, 1);
        chk("autoboot_busy", bus.busy, 1);

        // Basic three-word image.
        stream = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hFF, 8'h3F, 8'h00, 8'h00};
        run_load("img3", 0, 3, -1);

        // Bad lengths.
        stream = '{8'h00, 8'h00};
        run_load("len0", 0, 2, -1);
        stream = '{8'h01, 8'h04};
        run_load("len1025", 0, 2, -1);

        // Bad data word after one good write, then recovery.
        stream = '{8'h02, 8'h00, 8'hAA, 8'h15, 8'h55, 8'h40};
        run_load("badword", 0, 2, -1);
        pulse_start();
        chk("recover_err_clr", bus.err, 0);
        chk("recover_busy", bus.busy, 1);
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h04};
        run_load("recover", 0, 2, -1);

        // Timeout after entering LEN_LO with the source silent.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("to_ready", bus.src_ready, 1);
        repeat (15) tick();
        chk("to_early", bus.err, 0);
        tick();
        chk("to_err", bus.err, 1);
        chk("to_code", bus.err_code, 3);
        chk("to_core_rst", bus.core_reset, 1);

        // Slow but steady source stays under the timeout.
        stream = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        run_load("slow", 9, 9, -1);

        // Reset while the high byte of word 5 is pending.
        stream.delete();
        stream.push_back(8'h08);
        stream.push_back(8'h00);
        for (int i = 0; i < 8; i++) push_word(14'(16'h0100 + i * 16'h0111), 2'b00);
        if (bus.done || bus.err) pulse_start();
        model();
        exp_used = 2 + 2 * 5 + 1;
        send(0, 2, -1);
        tick();
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        run_load("reload", 0, 3, -1);

        // Reload request from RUN, with a stray start mid-load.
        chk("run_done", bus.done, 1);
        pulse_start();
        chk("restart_core_rst", bus.core_reset, 1);
        chk("restart_done", bus.done, 0);
        chk("restart_busy", bus.busy, 1);
        stream = '{8'h03, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'h5A, 8'h2A};
        run_load("start_ign", 0, 2, 5);

        // Randomized images.
        for (int t = 0; t < 12; t++) begin
            build_random();
            model();
            run_load($sformatf("rnd%0d", t), 0, 3,
                     ($urandom_range(3, 0) == 0) ? $urandom_range(exp_used - 1, 0) : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
